// File: rtl/seq_alu_core.sv
// seq_alu_core: multi-cycle unsigned ALU (ADD/SUB/MUL/DIV) with valid/ready
// handshakes on both sides and a 2*WIDTH-bit result plus status flags.
// MUL is iterative shift-add and DIV is restoring division; both take WIDTH
// EXEC cycles. ADD, SUB and divide-by-zero finish after one EXEC cycle.
// Optional feature macro ALU_ACC_EN adds an acc_sel port and a WIDTH-bit
// accumulator. The accumulator captures result[WIDTH-1:0] on every output
// handshake and can stand in for operand A at accept.
//
// state  | meaning
// S_IDLE | waiting for an operation, in_ready high
// S_EXEC | iterating; one shift-add / restoring step per cycle
// S_DONE | result and flags held until out_ready
module seq_alu_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef ALU_ACC_EN
  input  logic                 acc_sel,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_carry,
  output logic                 flag_zero,
  output logic                 flag_dbz,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_src;

  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [2*WIDTH-1:0] fin_result;
  logic               fin_carry;
  logic               fin_dbz;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0]   acc;
  assign a_src = acc_sel ? acc : a;
`else
  assign a_src = a;
`endif

  // One iteration step for MUL/DIV and the final result/flags for each op
  always_comb begin
    mul_add    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    mul_next   = {mul_add, p[WIDTH-1:1]};
    // 2*rem + bit < 2*b, so the shifted partial remainder always fits in WIDTH+1 bits
    div_shift  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_diff   = div_shift - {1'b0, b_r};
    div_ge     = (div_shift >= {1'b0, b_r});
    div_rem    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next   = {div_rem, p[WIDTH-2:0], div_ge};
    add_sum    = {1'b0, a_r} + {1'b0, b_r};
    sub_diff   = {1'b0, a_r} - {1'b0, b_r};
    fin_result = '0;
    fin_carry  = 1'b0;
    fin_dbz    = 1'b0;
    case (op_r)
      OP_ADD: begin
        fin_result = {{(WIDTH-1){1'b0}}, add_sum};
        fin_carry  = add_sum[WIDTH];
      end
      OP_SUB: begin
        fin_result = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
        fin_carry  = sub_diff[WIDTH];
      end
      OP_MUL: begin
        fin_result = mul_next;
        fin_carry  = |mul_next[2*WIDTH-1:WIDTH];
      end
      default: begin
        if (b_r == '0) begin
          fin_result = {a_r, {WIDTH{1'b1}}};
          fin_dbz    = 1'b1;
        end else begin
          fin_result = div_next;
        end
      end
    endcase
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      p          <= '0;
      cnt        <= '0;
      result     <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      flag_dbz   <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef ALU_ACC_EN
      acc        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            a_r      <= a_src;
            b_r      <= b;
            p        <= {{WIDTH{1'b0}}, a_src};
            // one step for ADD/SUB and DIV-by-zero, WIDTH steps otherwise
            if (op == OP_MUL || (op == OP_DIV && b != '0))
              cnt <= CW'(WIDTH - 1);
            else
              cnt <= '0;
            state    <= S_EXEC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op_r == OP_MUL)
            p <= mul_next;
          else if (op_r == OP_DIV)
            p <= div_next;
          if (cnt == '0) begin
            result     <= fin_result;
            flag_carry <= fin_carry;
            flag_zero  <= (fin_result == '0);
            flag_dbz   <= fin_dbz;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
`ifdef ALU_ACC_EN
            acc       <= result[WIDTH-1:0];
`endif
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed-vector bench for seq_alu_core at WIDTH=4.
module tb_seq_alu_core;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef ALU_ACC_EN
  logic           acc_sel;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           flag_carry;
  logic           flag_zero;
  logic           flag_dbz;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
`ifdef ALU_ACC_EN
    .acc_sel    (acc_sel),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .flag_dbz   (flag_dbz),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got stuck, expected completion");
    $fatal(1, "watchdog");
  end

  // Issue one operation and wait for out_valid; lat = -1 on timeout.
  // rdy_low reports whether in_ready stayed low for every EXEC cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output bit rdy_low);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    rdy_low = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef ALU_ACC_EN
    acc_sel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, result, flag_carry, flag_zero, flag_dbz} !== {3'b100, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b res=%h c=%b z=%b d=%b, expected rdy=1 ov=0 busy=0 res=00 flags=000",
               in_ready, out_valid, busy, result, flag_carry, flag_zero, flag_dbz);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b busy=%b, expected rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_add;
    int lat; bit rl;
    issue(2'b00, 4'd9, 4'd8, lat, rl);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d, expected 1", lat); end
    vectors++;
    if ({result, flag_carry, flag_zero, flag_dbz, busy, in_ready} !== {8'h11, 5'b10010}) begin
      miscompares++;
      $display("FAIL add_9_8: got res=%h c=%b z=%b d=%b busy=%b rdy=%b, expected res=11 c=1 z=0 d=0 busy=1 rdy=0",
               result, flag_carry, flag_zero, flag_dbz, busy, in_ready);
    end
    handshake();
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL add_release: got ov=%b rdy=%b busy=%b, expected ov=0 rdy=1 busy=0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_sub;
    int lat; bit rl;
    issue(2'b01, 4'd3, 4'd5, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h0E || flag_carry !== 1'b1 || flag_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_3_5: got lat=%0d res=%h c=%b z=%b, expected lat=1 res=0e c=1 z=0", lat, result, flag_carry, flag_zero);
    end
    handshake();
    issue(2'b01, 4'd5, 4'd5, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h00 || flag_carry !== 1'b0 || flag_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_5_5: got lat=%0d res=%h c=%b z=%b, expected lat=1 res=00 c=0 z=1", lat, result, flag_carry, flag_zero);
    end
    handshake();
  endtask

  task automatic test_mul;
    int lat; bit rl;
    issue(2'b10, 4'd15, 4'd15, lat, rl);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL mul_latency: got %0d, expected 4", lat); end
    vectors++;
    if (rl !== 1'b1) begin miscompares++; $display("FAIL mul_in_ready_low: got in_ready high during EXEC, expected low"); end
    vectors++;
    if (result !== 8'hE1 || flag_carry !== 1'b1 || flag_zero !== 1'b0 || flag_dbz !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_15_15: got res=%h c=%b z=%b d=%b, expected res=e1 c=1 z=0 d=0", result, flag_carry, flag_zero, flag_dbz);
    end
    handshake();
    issue(2'b10, 4'd0, 4'd5, lat, rl);
    vectors++;
    if (lat !== 4 || result !== 8'h00 || flag_carry !== 1'b0 || flag_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL mul_0_5: got lat=%0d res=%h c=%b z=%b, expected lat=4 res=00 c=0 z=1", lat, result, flag_carry, flag_zero);
    end
    handshake();
    issue(2'b10, 4'd3, 4'd5, lat, rl);
    vectors++;
    if (result !== 8'h0F || flag_carry !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_3_5: got res=%h c=%b, expected res=0f c=0", result, flag_carry);
    end
    handshake();
  endtask

  task automatic test_div;
    int lat; bit rl;
    issue(2'b11, 4'd13, 4'd4, lat, rl);
    vectors++;
    if (lat !== 4 || result !== 8'h13 || flag_carry !== 1'b0 || flag_dbz !== 1'b0 || flag_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL div_13_4: got lat=%0d res=%h c=%b d=%b z=%b, expected lat=4 res=13 c=0 d=0 z=0",
               lat, result, flag_carry, flag_dbz, flag_zero);
    end
    handshake();
    issue(2'b11, 4'd7, 4'd0, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h7F || flag_dbz !== 1'b1 || flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL div_7_0: got lat=%0d res=%h d=%b c=%b z=%b, expected lat=1 res=7f d=1 c=0 z=0",
               lat, result, flag_dbz, flag_carry, flag_zero);
    end
    handshake();
    issue(2'b11, 4'd15, 4'd1, lat, rl);
    vectors++;
    if (result !== 8'h0F || flag_dbz !== 1'b0) begin
      miscompares++;
      $display("FAIL div_15_1: got res=%h d=%b, expected res=0f d=0", result, flag_dbz);
    end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat; bit rl;
    issue(2'b10, 4'd6, 4'd7, lat, rl);
    for (int i = 0; i < 5; i++) begin
      op = 2'b00; a = 4'd1; b = 4'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, busy, result, flag_carry, flag_zero, flag_dbz} !== {3'b101, 8'h2A, 3'b100}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b busy=%b res=%h c=%b z=%b d=%b, expected ov=1 rdy=0 busy=1 res=2a c=1 z=0 d=0",
                 i, out_valid, in_ready, busy, result, flag_carry, flag_zero, flag_dbz);
      end
    end
    in_valid = 1'b0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b, expected ov=0 rdy=1", out_valid, in_ready);
    end
    issue(2'b01, 4'd9, 4'd2, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h07 || flag_carry !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_next_op: got lat=%0d res=%h c=%b, expected lat=1 res=07 c=0", lat, result, flag_carry);
    end
    handshake();
  endtask

  task automatic test_back_to_back;
    int lat; bit rl;
    issue(2'b00, 4'd15, 4'd15, lat, rl);
    vectors++;
    if (result !== 8'h1E || flag_carry !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_add: got res=%h c=%b, expected res=1e c=1", result, flag_carry);
    end
    handshake();
    issue(2'b01, 4'd0, 4'd1, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h0F || flag_carry !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_sub: got lat=%0d res=%h c=%b, expected lat=1 res=0f c=1", lat, result, flag_carry);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    int lat; bit rl;
    issue(2'b00, 4'd1, 4'd2, lat, rl);
    handshake();
    op = 2'b10; a = 4'd15; b = 4'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, result, flag_carry, flag_zero, flag_dbz} !== {3'b100, 8'h00, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_mid_mul: got rdy=%b ov=%b busy=%b res=%h c=%b z=%b d=%b, expected rdy=1 ov=0 busy=0 res=00 flags=000",
               in_ready, out_valid, busy, result, flag_carry, flag_zero, flag_dbz);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release: got rdy=%b busy=%b ov=%b, expected rdy=1 busy=0 ov=0", in_ready, busy, out_valid);
    end
    issue(2'b00, 4'd2, 4'd2, lat, rl);
    vectors++;
    if (lat !== 1 || result !== 8'h04) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got lat=%0d res=%h, expected lat=1 res=04", lat, result);
    end
    handshake();
  endtask

`ifdef ALU_ACC_EN
  task automatic test_acc;
    int lat; bit rl;
    acc_sel = 1'b0;
    issue(2'b00, 4'd3, 4'd4, lat, rl);
    handshake();
    acc_sel = 1'b1;
    issue(2'b00, 4'd0, 4'd1, lat, rl);
    acc_sel = 1'b0;
    vectors++;
    if (result !== 8'h08) begin
      miscompares++;
      $display("FAIL acc_add: got res=%h, expected res=08", result);
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_ACC_EN
    test_acc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
